// File: rtl/video_timing_gen.sv
// Raster timing source for the draw chain: pixel/line counters, sync/blank decode,
// background colour and frame/line strobes, packed onto one registered video bus.
module video_timing_gen #(
   parameter int          H_ACTIVE  = 800,
   parameter int          H_FP      = 40,
   parameter int          H_SYNC    = 128,
   parameter int          H_BP      = 88,
   parameter int          V_ACTIVE  = 600,
   parameter int          V_FP      = 1,
   parameter int          V_SYNC    = 4,
   parameter int          V_BP      = 23,
   parameter logic        SYNC_POL  = 1'b1,
   parameter logic [11:0] BG_COLOR  = 12'h48F,
   localparam int         BUS_WIDTH = 38
) (
   input  logic                 pclk,
   input  logic                 rst,
   input  logic                 en,
   output logic [BUS_WIDTH:0]   video_bus_out,
   output logic                 frame_start,
   output logic                 line_start,
   output logic [15:0]          frame_cnt
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   generate
      if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_bad_total
         $error("video_timing_gen: H_TOTAL and V_TOTAL must not exceed 2048");
      end
   endgenerate

   // 12-bit thresholds so a sync end of exactly 2048 still compares correctly
   localparam logic [11:0] HA  = 12'(H_ACTIVE);
   localparam logic [11:0] HS0 = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] HS1 = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [11:0] HL  = 12'(H_TOTAL - 1);
   localparam logic [11:0] VA  = 12'(V_ACTIVE);
   localparam logic [11:0] VS0 = 12'(V_ACTIVE + V_FP);
   localparam logic [11:0] VS1 = 12'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [11:0] VL  = 12'(V_TOTAL - 1);

   // r_pos_* is the position the bus will show on the next enabled cycle
   logic [10:0] r_pos_h;
   logic [10:0] r_pos_v;
   logic [10:0] r_hcount;
   logic [10:0] r_vcount;
   logic        r_hsync;
   logic        r_vsync;
   logic        r_hblank;
   logic        r_vblank;
   logic [11:0] r_rgb;
   logic        r_frame_start;
   logic        r_line_start;
   logic [15:0] r_frame_cnt;

   logic [11:0] w_ph;
   logic [11:0] w_pv;
   logic        w_h_last;
   logic        w_v_last;
   logic        w_hblank;
   logic        w_vblank;
   logic        w_hsync;
   logic        w_vsync;
   logic [11:0] w_rgb;
   logic        w_out_last;

   assign w_ph       = {1'b0, r_pos_h};
   assign w_pv       = {1'b0, r_pos_v};
   assign w_h_last   = (w_ph == HL);
   assign w_v_last   = (w_pv == VL);
   assign w_hblank   = (w_ph >= HA);
   assign w_vblank   = (w_pv >= VA);
   assign w_hsync    = (w_ph >= HS0 && w_ph < HS1) ? SYNC_POL : ~SYNC_POL;
   assign w_vsync    = (w_pv >= VS0 && w_pv < VS1) ? SYNC_POL : ~SYNC_POL;
   assign w_rgb      = (w_hblank | w_vblank) ? 12'h000 : BG_COLOR;
   // Bus currently shows the final pixel, so this advance completes a frame
   assign w_out_last = ({1'b0, r_hcount} == HL) && ({1'b0, r_vcount} == VL);

   always_ff @(posedge pclk) begin
      if (rst) begin
         r_pos_h       <= '0;
         r_pos_v       <= '0;
         r_hcount      <= '0;
         r_vcount      <= '0;
         r_hsync       <= ~SYNC_POL;
         r_vsync       <= ~SYNC_POL;
         r_hblank      <= 1'b0;
         r_vblank      <= 1'b0;
         r_rgb         <= BG_COLOR;
         r_frame_start <= 1'b0;
         r_line_start  <= 1'b0;
         r_frame_cnt   <= '0;
      end else if (en) begin
         r_hcount      <= r_pos_h;
         r_vcount      <= r_pos_v;
         r_hsync       <= w_hsync;
         r_vsync       <= w_vsync;
         r_hblank      <= w_hblank;
         r_vblank      <= w_vblank;
         r_rgb         <= w_rgb;
         r_line_start  <= (r_pos_h == 11'd0);
         r_frame_start <= (r_pos_h == 11'd0) && (r_pos_v == 11'd0);
         if (w_out_last) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
         end
         if (w_h_last) begin
            r_pos_h <= '0;
            r_pos_v <= w_v_last ? 11'd0 : r_pos_v + 11'd1;
         end else begin
            r_pos_h <= r_pos_h + 11'd1;
         end
      end else begin
         r_frame_start <= 1'b0;
         r_line_start  <= 1'b0;
      end
   end

   assign video_bus_out = {pclk, r_hcount, r_vcount, r_hsync, r_vsync,
                           r_hblank, r_vblank, r_rgb};
   assign frame_start   = r_frame_start;
   assign line_start    = r_line_start;
   assign frame_cnt     = r_frame_cnt;

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomized scoreboard bench for video_timing_gen on a reduced raster; expected
// bus values come from a linear pixel index since reset.
module tb_video_timing_gen;

   localparam int          HA  = 16;
   localparam int          HF  = 4;
   localparam int          HS  = 6;
   localparam int          HB  = 5;
   localparam int          VA  = 10;
   localparam int          VF  = 1;
   localparam int          VS  = 2;
   localparam int          VB  = 3;
   localparam int          HT  = HA + HF + HS + HB;
   localparam int          VT  = VA + VF + VS + VB;
   localparam int          FRAME = HT * VT;
   localparam logic        POL = 1'b1;
   localparam logic [11:0] BG  = 12'h48F;

   typedef struct packed {
      logic [37:0] bus;
      logic        fs;
      logic        ls;
      logic [15:0] fc;
   } exp_t;

   logic        pclk;
   logic        rst;
   logic        en;
   logic [38:0] video_bus_out;
   logic        frame_start;
   logic        line_start;
   logic [15:0] frame_cnt;

   exp_t q[$];
   exp_t cur;
   exp_t mon_e;
   int   t;
   int   n_total;
   int   n_pass;
   int   n_fs_exp;
   int   n_fs_seen;
   int   n_cyc;

   video_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .SYNC_POL(POL), .BG_COLOR(BG)
   ) dut (
      .pclk(pclk),
      .rst(rst),
      .en(en),
      .video_bus_out(video_bus_out),
      .frame_start(frame_start),
      .line_start(line_start),
      .frame_cnt(frame_cnt)
   );

   initial begin
      pclk = 1'b0;
      forever #5 pclk = ~pclk;
   end

   // Expected bus fields for a raster position, straight from the timing rules
   function automatic logic [37:0] fields(input int h, input int v);
      logic hb, vb, hs, vs;
      logic [11:0] rgb;
      hb  = (h >= HA);
      vb  = (v >= VA);
      hs  = (h >= HA + HF && h < HA + HF + HS) ? POL : ~POL;
      vs  = (v >= VA + VF && v < VA + VF + VS) ? POL : ~POL;
      rgb = (hb || vb) ? 12'h000 : BG;
      return {11'(h), 11'(v), hs, vs, hb, vb, rgb};
   endfunction

   task automatic step(input logic r, input logic e);
      @(negedge pclk);
      rst = r;
      en  = e;
      @(posedge pclk);
      if (r) begin
         t      = 0;
         cur.bus = {11'd0, 11'd0, ~POL, ~POL, 1'b0, 1'b0, BG};
         cur.fs = 1'b0;
         cur.ls = 1'b0;
         cur.fc = 16'd0;
      end else if (e) begin
         cur.bus = fields(t % HT, (t / HT) % VT);
         cur.ls  = ((t % HT) == 0);
         cur.fs  = ((t % FRAME) == 0);
         cur.fc  = 16'((t / FRAME) % 65536);
         if (cur.fs) n_fs_exp++;
         t++;
      end else begin
         cur.fs = 1'b0;
         cur.ls = 1'b0;
      end
      q.push_back(cur);
   endtask

   task automatic run(input int n, input int en_pct);
      for (int i = 0; i < n; i++) begin
         step(1'b0, ($urandom_range(0, 99) < en_pct) ? 1'b1 : 1'b0);
      end
   endtask

   task automatic check_pclk_field();
      #1;
      n_total++;
      if (video_bus_out[38] === 1'b1) n_pass++;
      else $display("FAIL pclk_field: got %b expected 1", video_bus_out[38]);
   endtask

   // Monitor: every cycle the DUT presents a bus word; compare against the queue
   always @(negedge pclk) begin
      if (q.size() > 0) begin
         mon_e = q.pop_front();
         n_cyc++;
         if (frame_start === 1'b1) n_fs_seen++;
         n_total++;
         if (video_bus_out === {1'b0, mon_e.bus} && frame_start === mon_e.fs &&
             line_start === mon_e.ls && frame_cnt === mon_e.fc) begin
            n_pass++;
         end else begin
            $display("FAIL bus cyc=%0d (got/exp) hc=%0d/%0d vc=%0d/%0d hs=%b/%b vs=%b/%b hb=%b/%b vb=%b/%b rgb=%h/%h pclk=%b/0 fs=%b/%b ls=%b/%b fcnt=%0d/%0d",
                     n_cyc,
                     video_bus_out[37:27], mon_e.bus[37:27],
                     video_bus_out[26:16], mon_e.bus[26:16],
                     video_bus_out[15], mon_e.bus[15],
                     video_bus_out[14], mon_e.bus[14],
                     video_bus_out[13], mon_e.bus[13],
                     video_bus_out[12], mon_e.bus[12],
                     video_bus_out[11:0], mon_e.bus[11:0],
                     video_bus_out[38],
                     frame_start, mon_e.fs, line_start, mon_e.ls,
                     frame_cnt, mon_e.fc);
         end
      end
   end

   initial begin
      rst = 1'b1;
      en  = 1'b0;
      t = 0; n_total = 0; n_pass = 0; n_fs_exp = 0; n_fs_seen = 0; n_cyc = 0;
      cur = '0;

      // Reset for 3 cycles with en high, then free-run two frames plus margin
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
      run(2 * FRAME + 40, 100);
      check_pclk_field();

      // Random enable gaps across line and frame boundaries
      run(1500, 75);

      // Long hold, then resume
      run(HT / 2, 100);
      run(10, 0);
      run(HT, 100);
      check_pclk_field();

      // Mid-frame resets, some with en asserted at the same time
      for (int k = 0; k < 5; k++) begin
         run($urandom_range(50, 2 * FRAME), 90);
         for (int i = 0; i < int'($urandom_range(1, 3)); i++) begin
            step(1'b1, $urandom_range(0, 1) != 0);
         end
      end
      run(2 * FRAME + 5, 100);

      @(negedge pclk);
      #1;
      n_total++;
      if (q.size() == 0) n_pass++;
      else $display("FAIL drain: got %0d pending expected 0", q.size());

      n_total++;
      if (n_fs_seen == n_fs_exp) n_pass++;
      else $display("FAIL frame_start_count: got %0d expected %0d", n_fs_seen, n_fs_exp);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
